// File: rtl/button_conditioner.sv
// button_conditioner: conditions three raw pushbutton pins.
// Each channel runs the pin through a 2-flop synchronizer and a debounce
// counter. It presents a clean level and a one-cycle press pulse.
// Optional feature macro: HOLD_REPEAT_EN. When it is defined, holding player1
// or player2 produces auto-repeat press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_button,
  input  logic player1,
  input  logic player2,
  output logic reset_level,
  output logic reset_press,
  output logic p1_level,
  output logic p1_press,
  output logic p2_level,
  output logic p2_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = reset_button, 1 = player1, 2 = player2
  logic [2:0] pin_s;
  logic [2:0] level_s;
  logic [2:0] press_s;

  assign pin_s = {player2, player1, reset_button};

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic          s1_r;
    logic          s2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;
    logic          rise_s;
    logic          fall_s;

    // The synced value has disagreed with the level long enough to be accepted
    assign accept_s = (s2_r != level_r) && (cnt_r == CNT_MAX);
    assign rise_s   = accept_s && s2_r;
    assign fall_s   = accept_s && !s2_r;

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1_r <= 1'b0;
        s2_r <= 1'b0;
      end else begin
        s1_r <= pin_s[ch];
        s2_r <= s1_r;
      end
    end

    // Debounce: count cycles of disagreement, accept the new level at the limit
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_r   <= '0;
        level_r <= 1'b0;
      end else if (s2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        level_r <= s2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end

`ifdef HOLD_REPEAT_EN
    if (ch != 0) begin : g_rep
      localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
      localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_cnt_r;
      logic          rep_first_r;
      logic          rep_fire_s;

      // A repeat is due only while the level stays high through this edge
      assign rep_fire_s = level_r && !fall_s &&
                          (rep_first_r ? (rep_cnt_r == DELAY_MAX) : (rep_cnt_r == PERIOD_MAX));

      // Repeat timer: restarts on a press and on every repeat, clears on release
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rep_cnt_r   <= '0;
          rep_first_r <= 1'b0;
        end else if (rise_s) begin
          rep_cnt_r   <= '0;
          rep_first_r <= 1'b1;
        end else if (level_r && !fall_s) begin
          if (rep_fire_s) begin
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b0;
          end else begin
            rep_cnt_r <= rep_cnt_r + 1'b1;
          end
        end else begin
          rep_cnt_r   <= '0;
          rep_first_r <= 1'b0;
        end
      end

      // Press pulse on the accepted rising level or on a due repeat
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          press_r <= 1'b0;
        end else begin
          press_r <= rise_s || rep_fire_s;
        end
      end
    end else begin : g_norep
      // Press pulse on the accepted rising level only
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          press_r <= 1'b0;
        end else begin
          press_r <= rise_s;
        end
      end
    end
`else
    // Press pulse on the accepted rising level only
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        press_r <= 1'b0;
      end else begin
        press_r <= rise_s;
      end
    end
`endif

    assign level_s[ch] = level_r;
    assign press_s[ch] = press_r;
  end

`ifndef HOLD_REPEAT_EN
  // Repeat timing has no effect in this build
  logic unused_repeat_s;
  assign unused_repeat_s = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  assign reset_level = level_s[0];
  assign reset_press = press_s[0];
  assign p1_level    = level_s[1];
  assign p1_press    = press_s[1];
  assign p2_level    = level_s[2];
  assign p2_press    = press_s[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a reference model predicts levels
// and press pulses each edge, and a monitor compares them on the falling edge.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
`ifdef HOLD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, reset_button, player1, player2;
  logic reset_level, reset_press, p1_level, p1_press, p2_level, p2_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .reset_button(reset_button),
    .player1(player1),
    .player2(player2),
    .reset_level(reset_level),
    .reset_press(reset_press),
    .p1_level(p1_level),
    .p1_press(p1_press),
    .p2_level(p2_level),
    .p2_press(p2_press)
  );

  typedef struct {
    bit [2:0] lvl;
    bit [2:0] prs;
    int       cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: pin history, accepted level, disagreement run, press time
  bit   hist_q[3][$];
  bit   m_lvl[3];
  int   m_run[3];
  int   m_pe[3];
  int   cyc = 0;

  // Predict the outputs that follow the edge just taken
  task automatic model_edge();
    exp_t e;
    bit   pin[3];
    bit   d;
    int   age;
    pin[0] = reset_button;
    pin[1] = player1;
    pin[2] = player2;
    cyc++;
    e.cyc = cyc;
    for (int ch = 0; ch < 3; ch++) begin
      e.prs[ch] = 1'b0;
      if (!reset_n) begin
        hist_q[ch] = '{1'b0, 1'b0};
        m_lvl[ch]  = 1'b0;
        m_run[ch]  = 0;
        m_pe[ch]   = 0;
      end else begin
        // the debouncer sees the pin as it was two edges ago
        d = hist_q[ch].pop_front();
        hist_q[ch].push_back(pin[ch]);
        if (d != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == D) begin
            m_lvl[ch] = d;
            m_run[ch] = 0;
            if (d) begin
              e.prs[ch] = 1'b1;
              m_pe[ch]  = cyc;
            end
          end
        end else begin
          m_run[ch] = 0;
        end
        if (REP_EN && ch != 0 && m_lvl[ch] && !e.prs[ch]) begin
          age = cyc - m_pe[ch];
          if (age == RD || (age > RD && ((age - RD) % RP) == 0)) e.prs[ch] = 1'b1;
        end
      end
      e.lvl[ch] = m_lvl[ch];
    end
    sb_q.push_back(e);
  endtask

  // Apply one input vector for n clock edges
  task automatic drive(input bit r, input bit b0, input bit b1, input bit b2, input int n);
    for (int i = 0; i < n; i++) begin
      reset_n      = r;
      reset_button = b0;
      player1      = b1;
      player2      = b2;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Monitor: compare DUT outputs with the queued prediction away from the edge
  initial begin
    exp_t e;
    bit   act_l[3];
    bit   act_p[3];
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act_l[0] = reset_level; act_p[0] = reset_press;
        act_l[1] = p1_level;    act_p[1] = p1_press;
        act_l[2] = p2_level;    act_p[2] = p2_press;
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (act_l[ch] !== e.lvl[ch]) begin
            errors++;
            $display("FAIL level ch%0d cycle %0d: got %0b want %0b", ch, e.cyc, act_l[ch], e.lvl[ch]);
          end
          checks++;
          if (act_p[ch] !== e.prs[ch]) begin
            errors++;
            $display("FAIL press ch%0d cycle %0d: got %0b want %0b", ch, e.cyc, act_p[ch], e.prs[ch]);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized hold lengths with rare resets
  initial begin
    bit val[3];
    int rem[3];
    for (int ch = 0; ch < 3; ch++) hist_q[ch] = '{1'b0, 1'b0};
    // reset held with all pins pressed, then release: one press per channel
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 12);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    // clean press and release on player1
    drive(1'b1, 1'b0, 1'b1, 1'b0, 9);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    // bouncing player2 then held
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    // short glitch on reset_button
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8);
    // simultaneous long hold on both players, then release
    drive(1'b1, 1'b0, 1'b1, 1'b1, 30);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    // player1 released between repeat pulses
    drive(1'b1, 1'b0, 1'b1, 1'b0, 19);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12);
    // long hold on reset_button
    drive(1'b1, 1'b1, 1'b0, 1'b0, 30);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    // reset in the middle of a pending count
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 12);
    // randomized phase
    for (int ch = 0; ch < 3; ch++) begin
      val[ch] = 1'b0;
      rem[ch] = 0;
    end
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (rem[ch] == 0) begin
          val[ch] = ~val[ch];
          rem[ch] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 7));
        end
        rem[ch]--;
      end
      drive(($urandom_range(0, 199) != 0), val[0], val[1], val[2], 1);
    end
    repeat (2) @(posedge clk);
    #6;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
